// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// master: requester (drives start/operands); slave: the subtractor.
interface serial_subtractor_if #(
  parameter int BW = 32,
  parameter int DW = 8
) ();
  logic          start;
  logic [BW-1:0] A;
  logic [BW-1:0] B;
  logic          bin;
  logic          busy;
  logic          done;
  logic [BW-1:0] diff;
  logic          bout;
  logic          ovf;

  modport master (
    output start, A, B, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, A, B, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle A - B - bin, DW bits per clock, LSB slice first.
// Optional signed overflow output: define SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int BW = 32,
  parameter int DW = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  serial_subtractor_if.slave sif
);
  localparam int N  = BW / DW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] a_sh;
  logic [BW-1:0] b_sh;
  logic [BW-1:0] r_sh;
  logic          borrow;
  logic          busy_q;
  logic          done_q;
  logic [BW-1:0] diff_q;
  logic          bout_q;

  logic [DW:0]   slice;
  logic [BW-1:0] r_next;
  logic          last;

  // Operands shift right so the current slice always sits at bit 0;
  // results enter at the top so the word is aligned after N slices.
  always_comb begin
    slice  = {1'b0, a_sh[DW-1:0]} - {1'b0, b_sh[DW-1:0]} - {{DW{1'b0}}, borrow};
    r_next = (r_sh >> DW) | (BW'(slice[DW-1:0]) << (BW - DW));
    last   = (cnt == CW'(N - 1));
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      borrow <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sif.start) begin
            a_sh   <= sif.A;
            b_sh   <= sif.B;
            borrow <= sif.bin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DW;
          b_sh   <= b_sh >> DW;
          r_sh   <= r_next;
          borrow <= slice[DW];
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff_q <= r_next;
            bout_q <= slice[DW];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.busy = busy_q;
  assign sif.done = done_q;
  assign sif.diff = diff_q;
  assign sif.bout = bout_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Sign bits are kept separately because the operand registers shift away.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == IDLE) begin
      if (sif.start) begin
        a_msb <= sif.A[BW-1];
        b_msb <= sif.B[BW-1];
      end
    end else if (last) begin
      ovf_q <= (a_msb ^ b_msb) & (slice[DW-1] ^ a_msb);
    end
  end

  assign sif.ovf = ovf_q;
`else
  assign sif.ovf = 1'b0;
`endif
endmodule
